// File: rtl/masked_serial_incrementer.sv
// Bit-serial 2-share masked incrementer: adds a masked increment bit to a masked WIDTH-bit
// operand one bit per step, drawing one fresh random bit per step for the masked carry AND.

module half_adder_masked (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic r,
  output logic s0,
  output logic s1,
  output logic c0,
  output logic c1
);

  assign s0 = a0 ^ b0;
  assign s1 = a1 ^ b1;

  // ISW AND: r refreshes the cross terms so no carry share sees both shares of a value.
  assign c0 = (a0 & b0) ^ r;
  assign c1 = (a1 & b1) ^ ((r ^ (a0 & b1)) ^ (a1 & b0));

endmodule

module masked_serial_incrementer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] i_A0,
  input  logic [WIDTH-1:0] i_A1,
  input  logic             i_cin0,
  input  logic             i_cin1,
  input  logic             rnd_valid,
  input  logic             rnd,
  output logic             rnd_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o_sum0,
  output logic [WIDTH-1:0] o_sum1,
  output logic             o_carry0,
  output logic             o_carry1
);

  // Encoding chosen so busy/done come straight off state flops.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StStep = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [WIDTH-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
  logic             carry0_q, carry0_d, carry1_q, carry1_d;
  logic             ha_s0, ha_s1, ha_c0, ha_c1;

  half_adder_masked u_ha (
    .a0 (a0_q[0]),
    .a1 (a1_q[0]),
    .b0 (carry0_q),
    .b1 (carry1_q),
    .r  (rnd),
    .s0 (ha_s0),
    .s1 (ha_s1),
    .c0 (ha_c0),
    .c1 (ha_c1)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    sum0_d   = sum0_q;
    sum1_d   = sum1_q;
    carry0_d = carry0_q;
    carry1_d = carry1_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StStep;
          idx_d    = '0;
          a0_d     = i_A0;
          a1_d     = i_A1;
          carry0_d = i_cin0;
          carry1_d = i_cin1;
          sum0_d   = '0;
          sum1_d   = '0;
        end
      end
      StStep: begin
        if (rnd_valid) begin
          // Operand shares shift right so the current bit is always at position 0.
          a0_d         = a0_q >> 1;
          a1_d         = a1_q >> 1;
          sum0_d[idx_q] = ha_s0;
          sum1_d[idx_q] = ha_s1;
          carry0_d     = ha_c0;
          carry1_d     = ha_c1;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      sum0_q   <= '0;
      sum1_q   <= '0;
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      sum0_q   <= sum0_d;
      sum1_q   <= sum1_d;
      carry0_q <= carry0_d;
      carry1_q <= carry1_d;
    end
  end

  assign busy      = state_q[0];
  assign rnd_ready = state_q[0];
  assign done      = state_q[1];
  assign o_sum0    = sum0_q;
  assign o_sum1    = sum1_q;
  assign o_carry0  = carry0_q;
  assign o_carry1  = carry1_q;

endmodule

// File: doc/masked_serial_incrementer.md
Name: masked_serial_incrementer

Overview:
- Bit-serial controller that adds a 2-share masked increment bit to a W-bit 2-share masked operand.
- Sequences one internal `half_adder_masked` instance over W steps, one bit per step.
- Supplies one fresh random bit per step through a valid/ready handshake and registers the carry shares between steps.
- Serves as the masked counter/increment primitive for the masked datapath; all outputs are registered.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- IDX_W, $clog2(WIDTH), step index counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- i_A0  input  WIDTH  operand share 0.
- i_A1  input  WIDTH  operand share 1.
- i_cin0  input  1  increment bit share 0.
- i_cin1  input  1  increment bit share 1.
- rnd_valid  input  1  fresh random bit available.
- rnd  input  1  fresh random bit, consumed when rnd_valid & rnd_ready.
- rnd_ready  output  1  controller consumes rnd this cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, results valid.
- o_sum0  output  WIDTH  result share 0.
- o_sum1  output  WIDTH  result share 1.
- o_carry0  output  1  carry-out share 0.
- o_carry1  output  1  carry-out share 1.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; index = 0.
  - busy, done, rnd_ready, o_sum0, o_sum1, o_carry0, o_carry1 all 0.
  - Internal operand and carry registers cleared.
- Unmasked value of any pair = share0 XOR share1.
  - Required result: {carry, sum} = A + cin, with A = i_A0^i_A1 and cin = i_cin0^i_cin1.
- States:
  - IDLE: busy=0.
    - start=1 -> latch i_A0/i_A1 into operand shift regs and i_cin0/i_cin1 into carry share regs; index=0; go to STEP.
  - STEP: busy=1; rnd_ready=1.
    - On an edge with rnd_valid=1, feed bit[index] of both operand shares, both carry shares and rnd into half_adder_masked.
    - Write sum shares into result bit[index].
    - Register the half-adder carry shares as the next carry shares.
    - index++.
    - If index==WIDTH-1 on that edge, go to DONE.
    - rnd_valid=0 -> stall: no state, index, carry or result change.
  - DONE: busy=0; rnd_ready=0; done=1 for exactly this cycle.
    - o_sum0/o_sum1/o_carry0/o_carry1 already hold the final shares.
    - Next edge -> IDLE.
- Latency: done is high in the cycle after the WIDTH-th accepted step. Minimum is start edge + WIDTH edges; each rnd_valid=0 cycle in STEP adds one cycle.
- Randomness: exactly WIDTH random bits consumed per operation; none outside STEP. Each random bit is used in exactly one step.
- Masking rules:
  - Shares are never combined unmasked.
  - Carry shares are registered between steps; no combinational path from carry of step k to step k+1.
  - Result bits are written share-wise only.
- Outputs:
  - o_sum*/o_carry* hold their values from DONE until the next start is accepted.
  - Result bits of the current operation update progressively during STEP.
- Simultaneous events:
  - start while busy or in DONE -> ignored.
  - rst_n low mid-STEP -> immediate return to IDLE with all outputs 0; no done pulse; partial results discarded.
- Wrap-around: A = all ones with cin = 1 -> sum 0, carry 1.
- cin = 0 -> sum = A, carry 0, still WIDTH steps and WIDTH random bits.

Test Plan:
- WIDTH=4, i_A0=4'b1010, i_A1=4'b0101 (A=15), cin shares 1/0, rnd_valid held 1 -> done 4 edges after start; sum shares XOR 4'b0000; carry XOR 1; exactly 4 rnd handshakes.
- WIDTH=8, A=8'h3C as shares 8'hA5/8'h99, cin shares 1/1 (cin=0) -> sum XOR 8'h3C; carry XOR 0.
- WIDTH=8, A=8'h7F, cin=1, rnd_valid toggling 1,0,1,0... -> done after 16 edges; sum XOR 8'h80; carry 0; state and outputs frozen on rnd_valid=0 cycles.
- start pulsed again during STEP and in DONE -> ignored; exactly one done pulse; result unchanged.
- rst_n asserted low at step 3 of 8 -> all outputs 0 immediately, busy 0, no done; a new start then completes correctly (A=8'h01, cin=1 -> 8'h02).
- Random rnd sequences with fixed A=8'hFF, cin=1 over 100 runs -> unmasked result always sum 8'h00, carry 1; individual shares vary with rnd.
